// File: rtl/sm_step_ctrl.sv
// Step-key / run-switch conditioner producing the core clock enable, step pulses and a step counter.
// Latency: key_pressed moves DEBOUNCE_CYCLES+2 edges after a new raw key level; step_pulse/clkEnable on that same edge; run reaches clkEnable on the 3rd edge.
// Backpressure: none; outputs are free-running registered levels and pulses with no ready/credit handshake.
module sm_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       run,
  output logic       clkEnable,
  output logic       step_pulse,
  output logic       key_pressed,
  output logic [7:0] step_count
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DB_W-1:0]  DB_TC     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [REP_W-1:0] DELAY_TC  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_TC = REP_W'(REPEAT_PERIOD - 1);
  localparam bit               REP_ON    = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [1:0]       key_sync;
  logic [1:0]       run_sync;
  logic             key_s;
  logic             run_s;

  logic [DB_W-1:0]  db_cnt;
  logic             db_diff;
  logic             db_toggle;
  logic             kp_rise;

  state_t           state;
  state_t           state_nxt;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_nxt;
  logic             pulse_nxt;

  // Two-flop synchronisers; key stages idle at 1 (released), run stages at 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_sync <= 2'b11;
      run_sync <= 2'b00;
    end else begin
      key_sync <= {key_sync[0], key_n};
      run_sync <= {run_sync[0], run};
    end
  end

  assign key_s = ~key_sync[1];
  assign run_s = run_sync[1];

  // Debounce decode: flip only once DEBOUNCE_CYCLES differing cycles have accumulated and the level still differs
  always_comb begin
    db_diff   = (key_s != key_pressed);
    db_toggle = db_diff && (db_cnt == DB_TC);
    kp_rise   = db_toggle && !key_pressed;
  end

  // Debounce counter and debounced key level; any agreeing cycle restarts the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt      <= '0;
      key_pressed <= 1'b0;
    end else if (!db_diff) begin
      db_cnt      <= '0;
    end else if (db_toggle) begin
      db_cnt      <= '0;
      key_pressed <= ~key_pressed;
    end else begin
      db_cnt      <= db_cnt + DB_W'(1);
    end
  end

  // Step FSM state, shared repeat counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rep_cnt    <= '0;
      step_pulse <= 1'b0;
      clkEnable  <= 1'b0;
      step_count <= 8'd0;
    end else begin
      state      <= state_nxt;
      rep_cnt    <= rep_cnt_nxt;
      step_pulse <= pulse_nxt;
      clkEnable  <= run_s | pulse_nxt;
      step_count <= step_count + {7'd0, step_pulse};
    end
  end

  // Next-state: the rising debounced edge starts a step, release always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (kp_rise) state_nxt = HOLD;
      HOLD: begin
        if (!key_pressed)                          state_nxt = IDLE;
        else if (REP_ON && (rep_cnt == DELAY_TC))  state_nxt = REPEAT;
      end
      REPEAT:  if (!key_pressed) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: pulse on press and on each terminal count; release is checked first so it beats a coincident terminal count
  always_comb begin
    pulse_nxt   = 1'b0;
    rep_cnt_nxt = '0;
    case (state)
      IDLE: begin
        pulse_nxt = kp_rise;
      end
      HOLD: begin
        if (!key_pressed) begin
          rep_cnt_nxt = '0;
        end else if (REP_ON && (rep_cnt == DELAY_TC)) begin
          pulse_nxt   = 1'b1;
          rep_cnt_nxt = '0;
        end else if (REP_ON) begin
          rep_cnt_nxt = rep_cnt + REP_W'(1);
        end else begin
          rep_cnt_nxt = rep_cnt;
        end
      end
      REPEAT: begin
        if (!key_pressed) begin
          rep_cnt_nxt = '0;
        end else if (rep_cnt == PERIOD_TC) begin
          pulse_nxt   = 1'b1;
          rep_cnt_nxt = '0;
        end else begin
          rep_cnt_nxt = rep_cnt + REP_W'(1);
        end
      end
      default: begin
        pulse_nxt   = 1'b0;
        rep_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Directed bench for sm_step_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
// Edge numbering inside each task: e=0 is the first edge that samples the newly driven input.
module tb_sm_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_n;
  logic       run;
  logic       clkEnable;
  logic       step_pulse;
  logic       key_pressed;
  logic [7:0] step_count;

  int errors = 0;
  int checks = 0;

  sm_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN      (1),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .run        (run),
    .clkEnable  (clkEnable),
    .step_pulse (step_pulse),
    .key_pressed(key_pressed),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = 1'b1;
    run   = 1'b0;
    repeat (3) tick();
    checks++; if (clkEnable !== 1'b0)   begin errors++; $display("FAIL reset_clkEnable got=%0b exp=0", clkEnable); end
    checks++; if (step_pulse !== 1'b0)  begin errors++; $display("FAIL reset_step_pulse got=%0b exp=0", step_pulse); end
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset_key_pressed got=%0b exp=0", key_pressed); end
    checks++; if (step_count !== 8'd0)  begin errors++; $display("FAIL reset_step_count got=%0d exp=0", step_count); end
  endtask

  task automatic test_idle();
    int bad = 0;
    rst_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (clkEnable !== 1'b0 || step_pulse !== 1'b0 || key_pressed !== 1'b0 || step_count !== 8'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_outputs nonzero_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_bounce();
    int rises  = 0;
    int pulses = 0;
    key_n = 1'b0;
    for (int e = 0; e < 24; e++) begin
      tick();
      if (key_pressed === 1'b1) rises++;
      if (step_pulse === 1'b1) pulses++;
      // low for edges 0-2, high 3-4, low 5-7, then high
      key_n = !(((e + 1) < 3) || (((e + 1) >= 5) && ((e + 1) < 8)));
    end
    checks++; if (rises != 0)          begin errors++; $display("FAIL bounce_key_pressed high_cycles=%0d exp=0", rises); end
    checks++; if (pulses != 0)         begin errors++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
    checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL bounce_step_count got=%0d exp=0", step_count); end
  endtask

  task automatic test_press();
    int pulses = 0;
    int ce_hi  = 0;
    key_n = 1'b0;
    for (int e = 0; e < 25; e++) begin
      tick();
      if (step_pulse === 1'b1) pulses++;
      if (clkEnable === 1'b1) ce_hi++;
      if (e == 5) begin
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL press_kp_early got=%0b exp=0", key_pressed); end
      end
      if (e == 6) begin
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL press_kp_rise got=%0b exp=1", key_pressed); end
        checks++; if (step_pulse !== 1'b1)  begin errors++; $display("FAIL press_pulse got=%0b exp=1", step_pulse); end
        checks++; if (clkEnable !== 1'b1)   begin errors++; $display("FAIL press_clkEnable got=%0b exp=1", clkEnable); end
      end
      if (e == 7) begin
        checks++; if (step_count !== 8'd1) begin errors++; $display("FAIL press_step_count got=%0d exp=1", step_count); end
      end
      if (e == 13) begin
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL press_kp_hold got=%0b exp=1", key_pressed); end
      end
      if (e == 14) begin
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL press_kp_release got=%0b exp=0", key_pressed); end
      end
      key_n = ((e + 1) <= 7) ? 1'b0 : 1'b1;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL press_pulse_total got=%0d exp=1", pulses); end
    checks++; if (ce_hi != 1)  begin errors++; $display("FAIL press_clkEnable_cycles got=%0d exp=1", ce_hi); end
  endtask

  task automatic test_repeat();
    logic [63:0] seen     = '0;
    logic [63:0] exp_mask = '0;
    int exp_edges[8] = '{6, 16, 19, 22, 25, 28, 31, 34};
    foreach (exp_edges[i]) exp_mask[exp_edges[i]] = 1'b1;
    key_n = 1'b0;
    for (int e = 0; e < 50; e++) begin
      tick();
      seen[e] = step_pulse;
      if (e == 35) begin
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL repeat_kp_hold got=%0b exp=1", key_pressed); end
      end
      if (e == 36) begin
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL repeat_kp_release got=%0b exp=0", key_pressed); end
      end
      key_n = ((e + 1) <= 29) ? 1'b0 : 1'b1;
    end
    checks++; if (seen !== exp_mask)   begin errors++; $display("FAIL repeat_pulse_edges got=%h exp=%h", seen, exp_mask); end
    checks++; if (step_count !== 8'd9) begin errors++; $display("FAIL repeat_step_count got=%0d exp=9", step_count); end
  endtask

  task automatic test_run_mode();
    int ce_drop = 0;
    run = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (clkEnable !== (e >= 2)) begin errors++; $display("FAIL run_on_edge%0d got=%0b exp=%0b", e, clkEnable, (e >= 2)); end
    end
    key_n = 1'b0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (clkEnable !== 1'b1) ce_drop++;
      key_n = ((e + 1) <= 7) ? 1'b0 : 1'b1;
    end
    checks++; if (ce_drop != 0)         begin errors++; $display("FAIL run_clkEnable_drop low_cycles=%0d exp=0", ce_drop); end
    checks++; if (step_count !== 8'd10) begin errors++; $display("FAIL run_step_count got=%0d exp=10", step_count); end
    run = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      checks++;
      if (clkEnable !== (e < 2)) begin errors++; $display("FAIL run_off_edge%0d got=%0b exp=%0b", e, clkEnable, (e < 2)); end
    end
  endtask

  task automatic test_wrap_and_reset();
    int n    = 0;
    bit done = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    key_n = 1'b0;
    for (int e = 0; e < 2000 && !done; e++) begin
      tick();
      if (step_pulse === 1'b1) begin
        n++;
        if (n == 256) begin
          tick();
          checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL wrap_step_count got=%0d exp=0", step_count); end
        end
        if (n == 257) done = 1'b1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL wrap_timeout pulses=%0d exp=257", n); end
    tick();
    checks++; if (step_count !== 8'd1) begin errors++; $display("FAIL wrap_after_step_count got=%0d exp=1", step_count); end
    tick();
    // the next edge would be a repeat terminal count; reset must suppress it
    rst_n = 1'b0;
    tick();
    checks++; if (step_pulse !== 1'b0)  begin errors++; $display("FAIL midrep_reset_pulse got=%0b exp=0", step_pulse); end
    checks++; if (step_count !== 8'd0)  begin errors++; $display("FAIL midrep_reset_count got=%0d exp=0", step_count); end
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL midrep_reset_kp got=%0b exp=0", key_pressed); end
    checks++; if (clkEnable !== 1'b0)   begin errors++; $display("FAIL midrep_reset_clkEnable got=%0b exp=0", clkEnable); end
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 5) begin
        checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL redebounce_early_pulse got=%0b exp=0", step_pulse); end
      end
      if (e == 6) begin
        checks++; if (step_pulse !== 1'b1)  begin errors++; $display("FAIL redebounce_pulse got=%0b exp=1", step_pulse); end
        checks++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL redebounce_kp got=%0b exp=1", key_pressed); end
      end
    end
    key_n = 1'b1;
    repeat (20) tick();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_bounce();
    test_press();
    test_repeat();
    test_run_mode();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
